// File: rtl/decode_stage.sv
// Registered instruction decode stage: splits instructions into opcode/register/target
// fields behind a main + skid buffer. Optional illegal-opcode flag via DECODE_ILLEGAL_EN.
module decode_stage #(
  parameter int unsigned            INSTR_W    = 16,
  parameter int unsigned            OPC_W      = 4,
  parameter int unsigned            REG_AW     = 3,
  parameter int unsigned            PC_W       = 9,
  parameter logic [OPC_W-1:0]       JMP_OPC    = '1,
  parameter int unsigned            CNT_W      = 16,
  parameter logic [2**OPC_W-1:0]    LEGAL_MASK = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [REG_AW-1:0]  out_rd,
  output logic [REG_AW-1:0]  out_rs1,
  output logic [REG_AW-1:0]  out_rs2,
  output logic [PC_W-1:0]    out_target,
  output logic               out_is_jump,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   decode_cnt
);

  localparam int unsigned RD_LSB  = OPC_W;
  localparam int unsigned RS1_LSB = OPC_W + REG_AW;
  localparam int unsigned RS2_LSB = OPC_W + 2 * REG_AW;

  if (INSTR_W < OPC_W + 3 * REG_AW || INSTR_W < OPC_W + PC_W ||
      $bits(LEGAL_MASK) != 2 ** OPC_W) begin : g_bad_params
    $error("decode_stage: instruction too narrow for the configured fields");
  end

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [PC_W-1:0]   target;
    logic              is_jump;
    logic              illegal;
  } dec_t;

  dec_t             dec_c;
  dec_t             m_q, m_d;
  dec_t             s_q, s_d;
  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;
  logic             take_c;
  logic             m_free_c;
  logic             unused_instr_c;

  // Field extraction; upper instruction bits may go unused for some widths
  always_comb begin
    dec_c         = '0;
    dec_c.opcode  = in_instr[OPC_W-1:0];
    dec_c.rd      = in_instr[RD_LSB  +: REG_AW];
    dec_c.rs1     = in_instr[RS1_LSB +: REG_AW];
    dec_c.rs2     = in_instr[RS2_LSB +: REG_AW];
    dec_c.target  = in_instr[OPC_W   +: PC_W];
    dec_c.is_jump = (in_instr[OPC_W-1:0] == JMP_OPC);
`ifdef DECODE_ILLEGAL_EN
    dec_c.illegal = ~LEGAL_MASK[in_instr[OPC_W-1:0]];
`else
    dec_c.illegal = 1'b0;
`endif
  end

  assign unused_instr_c = ^in_instr;

  assign accept_c = in_valid & ~s_valid_q;
  assign take_c   = m_valid_q & out_ready;
  assign m_free_c = ~m_valid_q | out_ready;

  // Buffer control: flush wins, skid drains into main before new input is taken
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    cnt_d     = cnt_q;

    if (take_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free_c) begin
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept_c) begin
        m_d       = dec_c;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      s_d       = dec_c;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready    = ~s_valid_q;
  assign out_valid   = m_valid_q;
  assign out_opcode  = m_q.opcode;
  assign out_rd      = m_q.rd;
  assign out_rs1     = m_q.rs1;
  assign out_rs2     = m_q.rs2;
  assign out_target  = m_q.target;
  assign out_is_jump = m_q.is_jump;
  assign out_illegal = m_q.illegal;
  assign decode_cnt  = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (CNT_W = 4, LEGAL_MASK = 16'h00FF).
module tb_decode_stage;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned REG_AW  = 3;
  localparam int unsigned PC_W    = 9;
  localparam int unsigned CNT_W   = 4;
`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [OPC_W-1:0]   out_opcode;
  logic [REG_AW-1:0]  out_rd;
  logic [REG_AW-1:0]  out_rs1;
  logic [REG_AW-1:0]  out_rs2;
  logic [PC_W-1:0]    out_target;
  logic               out_is_jump;
  logic               out_illegal;
  logic [CNT_W-1:0]   decode_cnt;

  int n_vec = 0;
  int n_bad = 0;

  decode_stage #(
    .INSTR_W   (INSTR_W),
    .OPC_W     (OPC_W),
    .REG_AW    (REG_AW),
    .PC_W      (PC_W),
    .JMP_OPC   (4'hF),
    .CNT_W     (CNT_W),
    .LEGAL_MASK(16'h00FF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_target (out_target),
    .out_is_jump(out_is_jump),
    .out_illegal(out_illegal),
    .decode_cnt (decode_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_opcode", 32'(out_opcode), 32'd0);
    chk("rst_target", 32'(out_target), 32'd0);
    chk("rst_cnt", 32'(decode_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat 16'h1ABF: F / rd 3 / rs1 5 / rs2 6 / target 1AB
    in_valid  = 1'b1;
    in_instr  = 16'h1ABF;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_opcode", 32'(out_opcode), 32'hF);
    chk("single_rd", 32'(out_rd), 32'd3);
    chk("single_rs1", 32'(out_rs1), 32'd5);
    chk("single_rs2", 32'(out_rs2), 32'd6);
    chk("single_target", 32'(out_target), 32'h1AB);
    chk("single_jump", 32'(out_is_jump), 32'd1);
    chk("single_illegal", 32'(out_illegal), 32'(ILL_EN));
    chk("single_cnt_pre", 32'(decode_cnt), 32'd0);
    tick();
    chk("single_drained", 32'(out_valid), 32'd0);
    chk("single_cnt", 32'(decode_cnt), 32'd1);

    // Backpressure: A, B, C with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 16'h2341;
    tick();
    chk("bp_a_valid", 32'(out_valid), 32'd1);
    chk("bp_a_opcode", 32'(out_opcode), 32'd1);
    chk("bp_a_rd", 32'(out_rd), 32'd4);
    chk("bp_a_target", 32'(out_target), 32'h034);
    chk("bp_a_in_ready", 32'(in_ready), 32'd1);
    in_instr = 16'h5672;
    tick();
    chk("bp_b_in_ready", 32'(in_ready), 32'd0);
    chk("bp_b_opcode_hold", 32'(out_opcode), 32'd1);
    in_instr = 16'h7893;
    tick();
    chk("bp_c_in_ready", 32'(in_ready), 32'd0);
    chk("bp_c_opcode_hold", 32'(out_opcode), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", 32'(out_opcode), 32'd2);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    chk("bp_cnt_a", 32'(decode_cnt), 32'd2);
    tick();
    in_valid = 1'b0;
    chk("bp_out_c", 32'(out_opcode), 32'd3);
    chk("bp_out_c_rd", 32'(out_rd), 32'd1);
    chk("bp_out_c_rs1", 32'(out_rs1), 32'd1);
    chk("bp_cnt_b", 32'(decode_cnt), 32'd3);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_cnt_c", 32'(decode_cnt), 32'd4);

    // Flush with both entries full, an offered beat and a take in the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 16'h0004;
    tick();
    in_instr = 16'h0005;
    tick();
    chk("fl_full", 32'(in_ready), 32'd0);
    in_instr  = 16'h0006;
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_cnt_take", 32'(decode_cnt), 32'd5);
    // Flush discards a beat accepted in the same cycle
    flush     = 1'b0;
    out_ready = 1'b0;
    in_instr  = 16'h000A;
    tick();
    flush    = 1'b1;
    in_instr = 16'h000B;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("fl2_valid", 32'(out_valid), 32'd0);
    chk("fl2_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("fl2_nothing_left", 32'(out_valid), 32'd0);
    chk("fl2_cnt", 32'(decode_cnt), 32'd5);

    // Async reset with M and S full, checked before any clock edge
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 16'h0007;
    tick();
    in_instr = 16'h0008;
    tick();
    in_valid = 1'b0;
    chk("ar_pre_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_cnt", 32'(decode_cnt), 32'd0);
    chk("ar_opcode", 32'(out_opcode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-rate stream of 17 beats, covering every opcode and the counter wrap
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_instr = 16'h1230 | 16'(k % 16);
      tick();
      chk("st_valid", 32'(out_valid), 32'd1);
      chk("st_opcode", 32'(out_opcode), 32'(k % 16));
      chk("st_jump", 32'(out_is_jump), 32'((k % 16) == 15));
      chk("st_illegal", 32'(out_illegal), 32'(ILL_EN && ((k % 16) >= 8)));
      chk("st_cnt", 32'(decode_cnt), 32'(k % 16));
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_valid", 32'(out_valid), 32'd0);
    chk("wrap_cnt", 32'(decode_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
